// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// default datapath width and the legacy 16-bit XOR helper.
package alu_share_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned XOR16_W       = 16;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic [XOR16_W-1:0] xor16(input logic [XOR16_W-1:0] a,
                                               input logic [XOR16_W-1:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/alu16_shift_xor.sv
// Combinational shared ALU: XOR plus logical shifts and rotate-left.
// Only the low clog2(WIDTH) bits of b are used as the shift amount.
module alu16_shift_xor
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   xr;
  logic [2*WIDTH-1:0] rol_wide;

  assign sh = b[SHW-1:0];

  // The 16-bit build reuses the existing xor16 helper; other widths fall back to a plain XOR.
  if (WIDTH == XOR16_W) begin : g_xor16
    assign xr = xor16(a, b);
  end else begin : g_xorw
    assign xr = a ^ b;
  end

  // Rotate by shifting a doubled copy and keeping the upper half.
  assign rol_wide = {a, a} << sh;

  always_comb begin
    y = xr;
    case (op)
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_ROL:  y = rol_wide[2*WIDTH-1:WIDTH];
      default: y = xr;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one ALU between two requesters;
// one operation in flight, result returned on a tagged response channel.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state;
  logic             last_id;
  logic [1:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_id;
  logic [WIDTH-1:0] alu_y;
  logic             gnt_any;
  logic             gnt_id;

  // On contention the requester that did not win last goes first.
  assign gnt_any    = (state == ST_IDLE) && (req0_valid || req1_valid);
  assign gnt_id     = (req0_valid && req1_valid) ? ~last_id : req1_valid;
  assign req0_ready = gnt_any && !gnt_id;
  assign req1_ready = gnt_any && gnt_id;

  alu16_shift_xor #(.WIDTH(WIDTH)) u_alu (
    .op (cap_op),
    .a  (cap_a),
    .b  (cap_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_id   <= 1'b1;
      cap_op    <= OP_XOR;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            cap_op  <= gnt_id ? req1_op : req0_op;
            cap_a   <= gnt_id ? req1_a  : req0_a;
            cap_b   <= gnt_id ? req1_b  : req0_b;
            cap_id  <= gnt_id;
            last_id <= gnt_id;
            busy    <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_y;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle model predicts grants and
// handshake timing, and expected results are queued at acceptance.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          phase   = 0;
  bit          m_last  = 1'b1;
  int          w0 = 0, w1 = 0;
  int          n_acc = 0;
  bit          acc0, acc1;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    int          n;
    n = int'(b[3:0]);
    case (op)
      2'b00: r = a ^ b;
      2'b01: r = a << n;
      2'b10: r = a >> n;
      default: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
      end
    endcase
    return r;
  endfunction

  // One clock: check outputs at negedge, advance the model at posedge, drop accepted valids.
  task automatic cyc();
    bit exp0, exp1, gid;
    @(negedge clk);
    exp0 = (phase == 0) && req0_valid && (!req1_valid || m_last == 1'b1);
    exp1 = (phase == 0) && req1_valid && (!req0_valid || m_last == 1'b0);
    if (!rst) begin
      chk("req0_ready", 32'(req0_ready), 32'(exp0));
      chk("req1_ready", 32'(req1_ready), 32'(exp1));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
      if (phase == 2) begin
        if (q.size() == 0) chk("rsp_underflow", 32'(1), 32'(0));
        else begin
          chk("rsp_data", 32'(rsp_data), 32'(q[0][15:0]));
          chk("rsp_id", 32'(rsp_id), 32'(q[0][16]));
        end
      end
    end
    @(posedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      phase  = 0;
      m_last = 1'b1;
      q.delete();
      w0 = 0;
      w1 = 0;
    end else begin
      case (phase)
        0: if (exp0 || exp1) begin
          gid = exp1;
          if (gid) begin
            q.push_back({1'b1, ref_alu(req1_op, req1_a, req1_b)});
            chk("starve1", 32'(w1 <= 2), 32'(1));
            w1 = 0;
            if (req0_valid) w0++;
            acc1 = 1'b1;
          end else begin
            q.push_back({1'b0, ref_alu(req0_op, req0_a, req0_b)});
            chk("starve0", 32'(w0 <= 2), 32'(1));
            w0 = 0;
            if (req1_valid) w1++;
            acc0 = 1'b1;
          end
          m_last = gid;
          n_acc++;
          phase = 1;
        end
        1: phase = 2;
        default: if (rsp_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          phase = 0;
        end
      endcase
    end
    #1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((phase != 0 || req0_valid || req1_valid || q.size() != 0) && n < max_cyc) begin
      cyc();
      n++;
    end
    if (n >= max_cyc) chk("idle_timeout", 32'(n), 32'(max_cyc - 1));
  endtask

  task automatic set0(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
  endtask

  initial begin
    int n;
    int issued;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;

    // Single XOR: 15 ^ 3 = 12
    rsp_ready = 1'b1;
    set0(2'b00, 16'd15, 16'd3);
    run_until_idle(20);

    // Contention, then alternation
    set0(2'b01, 16'd16, 16'd9);
    set1(2'b10, 16'h8000, 16'd4);
    run_until_idle(20);
    set0(2'b00, 16'hA5A5, 16'h0F0F);
    set1(2'b11, 16'h1234, 16'h0004);
    run_until_idle(20);

    // Rotate ignores upper b bits; shift of zero returns a
    set0(2'b11, 16'h8001, 16'h0011);
    run_until_idle(20);
    set1(2'b01, 16'h1234, 16'h0010);
    run_until_idle(20);
    set0(2'b10, 16'hBEEF, 16'hFFF0);
    run_until_idle(20);

    // Back-pressure with a waiting requester
    rsp_ready = 1'b0;
    set0(2'b01, 16'h00FF, 16'd3);
    cyc();
    set1(2'b00, 16'h5555, 16'hFFFF);
    n = 0;
    while (phase != 2 && n < 10) begin cyc(); n++; end
    chk("reach_resp", 32'(phase), 32'(2));
    repeat (5) cyc();
    rsp_ready = 1'b1;
    run_until_idle(20);

    // Reset during EXEC discards the operation and restores the pointer
    set1(2'b00, 16'h0001, 16'h0002);
    cyc();
    chk("in_exec", 32'(phase), 32'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set0(2'b01, 16'h0003, 16'd1);
    set1(2'b10, 16'h0300, 16'd1);
    run_until_idle(20);

    // Random soak
    issued = 0;
    n = 0;
    while ((issued < 1000 || phase != 0 || req0_valid || req1_valid) && n < 30000) begin
      if (!req0_valid && issued < 1000 && $urandom_range(0, 2) == 0) begin
        set0(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        issued++;
      end else if (req0_valid && $urandom_range(0, 7) == 0) req0_a = 16'($urandom);
      if (!req1_valid && issued < 1000 && $urandom_range(0, 2) == 0) begin
        set1(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        issued++;
      end else if (req1_valid && $urandom_range(0, 7) == 0) req1_b = 16'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    if (n >= 30000) chk("soak_timeout", 32'(n), 32'(0));
    chk("soak_queue_empty", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer sharing one 16-bit ALU datapath (xor16 plus logical/rotate shifter) between two requesters in the processor. Each requester presents an operation with operands under a valid/ready handshake. The block grants one request, registers the operands, executes on the shared ALU and returns a tagged result on a single response channel. Only one operation is in flight at a time.

## Interface

- WIDTH, 16: datapath width; shift amount field is clog2(WIDTH) bits (4 at default).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  opcode: 00 XOR, 01 SHL, 10 SHR, 11 ROL.
- req0_a  in  WIDTH  operand A (data to shift / XOR input).
- req0_b  in  WIDTH  operand B (XOR input; low 4 bits = shift amount).
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  index of the requester that issued the result.
- rsp_data  out  WIDTH  result.
- busy  out  1  high in EXEC and RESP.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester; reqN_ready=1 for the granted requester only (combinational, same cycle); capture op/a/b/id; next EXEC. With no valid, stay in IDLE.
- Arbitration: round-robin on pointer last_id. If both are valid, grant !last_id. If one is valid, grant it regardless of pointer. last_id updates to the granted id at acceptance.
- EXEC: ALU evaluates on captured operands; result registered into rsp_data; next RESP.
- RESP: rsp_valid=1; rsp_data and rsp_id held stable until rsp_ready=1; on handshake next IDLE.
- readys are 0 outside IDLE; requests presented then are not lost, they must be held by the requester (valid must stay high until ready).
- ALU rules, all modulo 2^WIDTH:
  - XOR = a ^ b.
  - SHL = a << b[3:0], zero fill.
  - SHR = a >> b[3:0], zero fill.
  - ROL = rotate a left by b[3:0].
  - b[WIDTH-1:4] ignored for shifts. Shift by 0 returns a.
- Reset values: state IDLE, last_id=1 (so requester 0 wins the first contention), rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, both readys 0.
- Reset mid-operation: in-flight operation discarded, no response issued, pointer returns to 1.

## Timing

- Accept at cycle N (valid&&ready) → EXEC at N+1 → rsp_valid first high at N+2.
- Result is held while rsp_ready=0; back-pressure of any length is legal.
- rsp handshake at cycle M → IDLE at M+1; next acceptance is possible at M+1.
- Peak throughput: one operation per 3 cycles.
- Simultaneous rsp handshake and new valid: the new request is not accepted until the following IDLE cycle.
- Opcode/operand changes on an unaccepted request are permitted and take effect at acceptance.

## Structure

- Shared package: opcode constants (OP_XOR, OP_SHL, OP_SHR, OP_ROL), state encoding typedef, default WIDTH.
- One sub-module: alu16_shift_xor, purely combinational (op, a, b → y). Instantiated once; it reuses the existing xor16 for the XOR path.
- Arbiter, FSM and output registers live in the top.

## Test plan

- Reset, then req0 XOR a=15 b=3 → req0_ready pulse, rsp_valid 2 cycles later, rsp_data=12, rsp_id=0.
- Both valid after reset: req0 SHL a=16 b=9, req1 SHR a=0x8000 b=4 → first response id 0 data 0x2000; second response id 1 data 0x0800; then both again → id 0 first (alternation).
- ROL a=0x8001 b=0x0011 → data 0x0003 (upper b bits ignored, shift 1); shift 0 returns a unchanged.
- rsp_ready held low 5 cycles → rsp_valid, rsp_data, rsp_id stable; readys stay 0 with req1_valid high throughout; req1 accepted the cycle after the handshake.
- rst asserted in EXEC → next cycle rsp_valid=0, busy=0, IDLE; then dual request grants req0.
- Random soak, 1000 ops, random valids and back-pressure → scoreboard matches reference model; no request starves (max wait ≤ 2 operations).
